fft_frame_sequencer: RTL and testbench
======================================

# fft_frame_sequencer

Top-level frame sequencer for the parallel FFT: accepts a stream of N input samples into the sample buffer, fires the FFT controller's start pulse, supervises computation with a watchdog, then paces result readout against the serial transmitter. Sits between the UART receive path, the FFT control/address-generation block (`flag_start_FFT`, `finish_FFT`, `en_out`, `out_valid`, `done_o`) and the UART transmit path. Owns frame-level state, error flags and the frame counter.

## Interface
- `N`, 16, FFT length in samples
- `SIZE`, 4, log2(N)
- `TIMEOUT`, 4096, max cycles from start pulse to `finish_FFT` before a watchdog error
- `clk` in 1: single system clock
- `rst_n` in 1: reset, asynchronous, active-low
- `in_valid` in 1: one input sample present this cycle
- `in_ready` out 1: sequencer accepts a sample this cycle
- `wr_en` out 1: sample buffer write strobe
- `wr_ptr` out SIZE: sample buffer write address
- `flag_start_FFT` out 1: one-cycle start pulse to the FFT controller
- `finish_FFT` in 1: one-cycle pulse, last FFT stage complete
- `tx_busy` in 1: transmitter busy
- `en_out` out 1: permit the output address generator to advance
- `out_valid` in 1: one result word read this cycle
- `done_o` in 1: pulse, output readout finished
- `abort` in 1: synchronous return to IDLE
- `clr_err` in 1: clear sticky error flags
- `busy` out 1: state is not IDLE
- `err_timeout` out 1: sticky watchdog error
- `err_overrun` out 1: sticky input-overrun error
- `err_count` out 1: sticky output word-count mismatch
- `frame_cnt` out 8: completed frames, wraps 255 -> 0

## Operation
- States: IDLE, LOAD, START, COMPUTE, OUTPUT, ERR.
- `in_ready` = 1 in IDLE and LOAD, 0 elsewhere. Accept = `in_valid & in_ready`.
- IDLE: accept writes the sample at `wr_ptr`=0 and moves to LOAD with `wr_ptr`=1.
- LOAD: each accept asserts `wr_en` (combinational with accept) at the current `wr_ptr`, then increments it. The accept at `wr_ptr`=N-1 moves to START, and `wr_ptr` wraps to 0.
- START: `flag_start_FFT`=1 for exactly this one cycle. The watchdog counter clears and the state moves to COMPUTE.
- COMPUTE: the watchdog increments each cycle.
  - `finish_FFT` -> OUTPUT, and the word counter clears.
  - If the watchdog reaches TIMEOUT-1 without `finish_FFT` -> ERR and `err_timeout` sets.
  - If `finish_FFT` arrives on that same cycle, `finish_FFT` wins.
- OUTPUT: `en_out` is registered and equals `!tx_busy` sampled the previous cycle (0 on OUTPUT entry cycle). Each `out_valid` increments the word counter (SIZE+1 bits). On `done_o`:
  - `frame_cnt` increments.
  - If the word count, including any `out_valid` in the same cycle, is not N, `err_count` sets.
  - The state moves to IDLE.
- ERR: holds until `abort` or `clr_err`, then goes to IDLE.
- `in_valid` while `in_ready`=0 sets `err_overrun`. The sample is dropped and the state is unaffected.
- `abort` (any state) -> IDLE next cycle; `wr_ptr`, watchdog and word counter clear. Error flags and `frame_cnt` are kept.
- `clr_err` clears all three error flags. A set event in the same cycle wins over the clear.
- In states other than OUTPUT, `en_out`=0 and `out_valid`/`done_o` are ignored.

## Timing
- Reset values: state IDLE; `wr_ptr`=0; `frame_cnt`=0; all errors 0; `wr_en`, `flag_start_FFT`, `en_out`, `busy` = 0; `in_ready`=1.
- The Nth accept at cycle t gives `flag_start_FFT`=1 at t+1.
- `finish_FFT` at cycle c gives OUTPUT at c+1 and earliest `en_out`=1 at c+2.
- `tx_busy` rising at cycle k gives `en_out`=0 at k+1.
- `done_o` at d gives `busy`=0 and `frame_cnt` updated at d+1. A new frame may be accepted at d+1.
- Reset asserted mid-frame returns all outputs to reset values immediately; partial buffer contents are don't-care.

## Test plan
- Reset, then 16 back-to-back `in_valid` -> `wr_ptr` steps 0..15, `wr_en` asserted 16 cycles, single `flag_start_FFT` one cycle after the 16th accept.
- `finish_FFT` 50 cycles after start, `tx_busy` toggling 3-on/2-off, 16 `out_valid`, then `done_o` -> `en_out` tracks `!tx_busy` delayed one cycle, `frame_cnt`=1, no errors.
- No `finish_FFT` with TIMEOUT=64 -> ERR with `err_timeout`=1 exactly 64 cycles after the start pulse; `clr_err` -> IDLE, flag 0.
- `in_valid` during COMPUTE -> `err_overrun`=1, `wr_ptr` unchanged, frame completes normally.
- `done_o` after 15 `out_valid` -> `err_count`=1, `frame_cnt` still increments.
- `abort` at sample 7 of LOAD -> IDLE next cycle, `wr_ptr`=0; the next 16 samples form a clean frame. Also run 256 frames and check `frame_cnt` wraps to 0.

Source files
------------

// File: rtl/fft_frame_sequencer_if.sv
// Frame-level handshake bundle between the FFT frame sequencer and its
// surroundings (UART rx/tx paths, sample buffer, FFT controller).
interface fft_frame_sequencer_if #(
   parameter int SIZE = 4
);
   logic            in_valid;
   logic            in_ready;
   logic            wr_en;
   logic [SIZE-1:0] wr_ptr;
   logic            flag_start_FFT;
   logic            finish_FFT;
   logic            tx_busy;
   logic            en_out;
   logic            out_valid;
   logic            done_o;
   logic            abort;
   logic            clr_err;
   logic            busy;
   logic            err_timeout;
   logic            err_overrun;
   logic            err_count;
   logic [7:0]      frame_cnt;

   modport master (
      input  in_valid, finish_FFT, tx_busy, out_valid, done_o, abort, clr_err,
      output in_ready, wr_en, wr_ptr, flag_start_FFT, en_out, busy,
             err_timeout, err_overrun, err_count, frame_cnt
   );

   modport slave (
      output in_valid, finish_FFT, tx_busy, out_valid, done_o, abort, clr_err,
      input  in_ready, wr_en, wr_ptr, flag_start_FFT, en_out, busy,
             err_timeout, err_overrun, err_count, frame_cnt
   );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer: loads N samples, starts the FFT, watches for completion,
// then paces result readout against the transmitter and tallies frames/errors.
module fft_frame_sequencer #(
   parameter int N       = 16,
   parameter int SIZE    = 4,
   parameter int TIMEOUT = 4096
) (
   input logic                   clk,
   input logic                   rst_n,
   fft_frame_sequencer_if.master bus
);
   localparam int WD_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_COMPUTE,
      S_OUTPUT,
      S_ERR
   } state_t;

   state_t          state_q, state_d;
   logic [SIZE-1:0] wr_ptr_q, wr_ptr_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic [SIZE:0]   word_q, word_d;
   logic [7:0]      frame_q, frame_d;
   logic            en_out_q, en_out_d;
   logic            err_to_q, err_to_d;
   logic            err_ov_q, err_ov_d;
   logic            err_ct_q, err_ct_d;

   logic            in_ready;
   logic            accept;
   logic [SIZE:0]   word_total;

   assign in_ready   = (state_q == S_IDLE) || (state_q == S_LOAD);
   assign accept     = bus.in_valid & in_ready;
   // Word total includes a result word arriving alongside done_o.
   assign word_total = word_q + {{SIZE{1'b0}}, bus.out_valid};

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      wd_d     = wd_q;
      word_d   = word_q;
      frame_d  = frame_q;
      en_out_d = 1'b0;
      err_to_d = err_to_q & ~bus.clr_err;
      err_ov_d = err_ov_q & ~bus.clr_err;
      err_ct_d = err_ct_q & ~bus.clr_err;

      if (bus.in_valid && !in_ready) begin
         err_ov_d = 1'b1;
      end

      if (bus.abort) begin
         state_d  = S_IDLE;
         wr_ptr_d = '0;
         wd_d     = '0;
         word_d   = '0;
      end else begin
         case (state_q)
            S_IDLE, S_LOAD: begin
               if (accept) begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  state_d  = (wr_ptr_q == SIZE'(N - 1)) ? S_START : S_LOAD;
               end
            end
            S_START: begin
               wd_d    = '0;
               state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
               wd_d = wd_q + 1'b1;
               // finish_FFT takes priority over a watchdog expiry in the same cycle.
               if (bus.finish_FFT) begin
                  state_d = S_OUTPUT;
                  word_d  = '0;
               end else if (wd_d == WD_W'(TIMEOUT - 1)) begin
                  state_d  = S_ERR;
                  err_to_d = 1'b1;
               end
            end
            S_OUTPUT: begin
               word_d = word_total;
               if (bus.done_o) begin
                  frame_d = frame_q + 8'd1;
                  state_d = S_IDLE;
                  if (word_total != (SIZE + 1)'(N)) begin
                     err_ct_d = 1'b1;
                  end
               end else begin
                  en_out_d = ~bus.tx_busy;
               end
            end
            S_ERR: begin
               if (bus.clr_err) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         wd_q     <= '0;
         word_q   <= '0;
         frame_q  <= '0;
         en_out_q <= 1'b0;
         err_to_q <= 1'b0;
         err_ov_q <= 1'b0;
         err_ct_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         wd_q     <= wd_d;
         word_q   <= word_d;
         frame_q  <= frame_d;
         en_out_q <= en_out_d;
         err_to_q <= err_to_d;
         err_ov_q <= err_ov_d;
         err_ct_q <= err_ct_d;
      end
   end

   assign bus.in_ready       = in_ready;
   assign bus.wr_en          = accept;
   assign bus.wr_ptr         = wr_ptr_q;
   assign bus.flag_start_FFT = (state_q == S_START);
   assign bus.en_out         = en_out_q;
   assign bus.busy           = (state_q != S_IDLE);
   assign bus.err_timeout    = err_to_q;
   assign bus.err_overrun    = err_ov_q;
   assign bus.err_count      = err_ct_q;
   assign bus.frame_cnt      = frame_q;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomized bench for fft_frame_sequencer against a frame-level reference model.
module tb_fft_frame_sequencer;
   localparam int N       = 16;
   localparam int SIZE    = 4;
   localparam int TIMEOUT = 64;
   localparam int MAX_CYC = 80000;
   localparam int FRAMES  = 265;

   localparam int PH_IDLE    = 0;
   localparam int PH_LOAD    = 1;
   localparam int PH_START   = 2;
   localparam int PH_COMPUTE = 3;
   localparam int PH_OUTPUT  = 4;
   localparam int PH_ERR     = 5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fft_frame_sequencer_if #(.SIZE(SIZE)) ifc ();

   fft_frame_sequencer #(.N(N), .SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model: phase, samples taken, start-pulse cycle, words read.
   int m_ph, m_cnt, m_start, m_words, m_frames, m_completed, m_fs;
   bit m_to, m_ov, m_ct, m_en;

   int fin_delay;
   int target;
   bit abort_done, rst_done;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_ph = PH_IDLE; m_cnt = 0; m_words = 0; m_frames = 0;
      m_to = 0; m_ov = 0; m_ct = 0; m_en = 0;
   endtask

   task automatic clear_inputs();
      ifc.in_valid = 0; ifc.finish_FFT = 0; ifc.tx_busy = 0; ifc.out_valid = 0;
      ifc.done_o = 0; ifc.abort = 0; ifc.clr_err = 0;
   endtask

   task automatic check_outputs();
      bit rdy;
      rdy = (m_ph == PH_IDLE) || (m_ph == PH_LOAD);
      chk("in_ready",    32'(ifc.in_ready),       32'(rdy));
      chk("wr_en",       32'(ifc.wr_en),          32'(ifc.in_valid && rdy));
      chk("wr_ptr",      32'(ifc.wr_ptr),         32'(m_cnt % N));
      chk("start_pulse", 32'(ifc.flag_start_FFT), 32'(m_ph == PH_START));
      chk("en_out",      32'(ifc.en_out),         32'(m_en));
      chk("busy",        32'(ifc.busy),           32'(m_ph != PH_IDLE));
      chk("err_timeout", 32'(ifc.err_timeout),    32'(m_to));
      chk("err_overrun", 32'(ifc.err_overrun),    32'(m_ov));
      chk("err_count",   32'(ifc.err_count),      32'(m_ct));
      chk("frame_cnt",   32'(ifc.frame_cnt),      32'(m_frames % 256));
   endtask

   // Advances the model across one clock edge using the inputs of this cycle.
   task automatic model_step();
      bit rdy;
      bit en_next;
      int words_now;
      rdy = (m_ph == PH_IDLE) || (m_ph == PH_LOAD);
      en_next = 0;
      if (ifc.clr_err) begin m_to = 0; m_ov = 0; m_ct = 0; end
      if (ifc.in_valid && !rdy) m_ov = 1;
      if (ifc.abort) begin
         m_ph = PH_IDLE; m_cnt = 0;
      end else begin
         case (m_ph)
            PH_IDLE, PH_LOAD:
               if (ifc.in_valid) begin
                  m_cnt++;
                  if (m_cnt == N) begin m_ph = PH_START; m_cnt = 0; end
                  else m_ph = PH_LOAD;
               end
            PH_START: begin m_ph = PH_COMPUTE; m_start = cyc; end
            PH_COMPUTE:
               if (ifc.finish_FFT) begin m_ph = PH_OUTPUT; m_words = 0; end
               else if (cyc - m_start == TIMEOUT - 1) begin m_ph = PH_ERR; m_to = 1; end
            PH_OUTPUT: begin
               words_now = m_words + (ifc.out_valid ? 1 : 0);
               if (ifc.done_o) begin
                  m_frames = (m_frames + 1) % 256;
                  m_completed++;
                  if (words_now != N) m_ct = 1;
                  m_ph = PH_IDLE;
               end else begin
                  m_words = words_now;
                  en_next = !ifc.tx_busy;
               end
            end
            PH_ERR: if (ifc.clr_err) m_ph = PH_IDLE;
            default: ;
         endcase
      end
      m_en = en_next;
   endtask

   // Per-frame stimulus knobs: a few frames are steered to the interesting cases.
   task automatic pick_frame();
      m_fs++;
      if (m_fs == 1)                                 fin_delay = 50;
      else if (m_fs == 3 || $urandom_range(0, 11) == 0) fin_delay = 100000;
      else if (m_fs == 4)                            fin_delay = TIMEOUT - 1;
      else                                           fin_delay = $urandom_range(1, 63);
      if (m_fs == 5)                        target = 15;
      else if ($urandom_range(0, 9) == 0)   target = ($urandom_range(0, 1) == 0) ? 15 : 17;
      else                                  target = 16;
   endtask

   task automatic drive();
      bit rdy;
      bit noise;
      rdy   = (m_ph == PH_IDLE) || (m_ph == PH_LOAD);
      noise = (m_completed >= 1);
      clear_inputs();
      ifc.tx_busy = (m_fs <= 1) ? ((cyc % 5) < 3) : ($urandom_range(0, 2) == 0);
      case (m_ph)
         PH_IDLE, PH_LOAD: begin
            ifc.in_valid = (m_fs == 0) ? 1'b1 : ($urandom_range(0, 7) != 0);
            if (m_completed >= 1 && !abort_done && m_ph == PH_LOAD && m_cnt == 7) begin
               ifc.abort  = 1;
               abort_done = 1;
            end
         end
         PH_COMPUTE: ifc.finish_FFT = (cyc - m_start == fin_delay);
         PH_OUTPUT: begin
            if (m_words >= target) ifc.done_o = (m_fs <= 1) || ($urandom_range(0, 1) == 1);
            else if (m_en && (m_fs <= 1 || $urandom_range(0, 3) != 0)) begin
               ifc.out_valid = 1;
               if (m_fs > 1 && m_words + 1 == target && $urandom_range(0, 2) == 0) ifc.done_o = 1;
            end
         end
         PH_ERR: ifc.clr_err = ($urandom_range(0, 4) == 0);
         default: ;
      endcase
      if (noise) begin
         if (!rdy && $urandom_range(0, 39) == 0) ifc.in_valid = 1;
         if (m_ph != PH_OUTPUT && $urandom_range(0, 29) == 0) ifc.out_valid = 1;
         if (m_ph != PH_OUTPUT && $urandom_range(0, 59) == 0) ifc.done_o = 1;
         if (m_ph != PH_COMPUTE && $urandom_range(0, 59) == 0) ifc.finish_FFT = 1;
         if ($urandom_range(0, 999) == 0) ifc.abort = 1;
         if ($urandom_range(0, 299) == 0) ifc.clr_err = 1;
      end
   endtask

   initial begin
      m_completed = 0; m_fs = 0; m_start = 0; fin_delay = 50; target = 16;
      abort_done = 0; rst_done = 0;
      model_reset();
      clear_inputs();
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      rst_n = 1;

      while (m_completed < FRAMES && cyc < MAX_CYC) begin
         if (!rst_done && m_completed == 3 && m_ph == PH_COMPUTE) begin
            rst_done = 1;
            clear_inputs();
            rst_n = 0;
            #1;
            model_reset();
            check_outputs();
            @(posedge clk);
            #1;
            rst_n = 1;
         end
         drive();
         @(negedge clk);
         check_outputs();
         model_step();
         if (m_ph == PH_START) pick_frame();
         cyc++;
         @(posedge clk);
         #1;
      end

      if (m_completed < FRAMES) chk("frames_completed", 32'(m_completed), 32'(FRAMES));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
